decoder_pipe: RTL

DECODER_PIPE -- requirements
Module: decoder_pipe

---
 rtl/decoder_pkg.sv | 14 +
 rtl/decoder_core.sv | 30 +++
 rtl/decoder_pipe.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and limits for the decoder_pipe block.
//   scan_state_t - states of the optional output-sweep FSM
//   SEL_W_MIN/MAX - legal range of the select width parameter
package decoder_pkg;

  localparam int SEL_W_MIN = 1;
  localparam int SEL_W_MAX = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/decoder_core.sv
// decoder_core: combinational select decoder.
//   sel  - select value
//   en   - 0 forces every output line inactive, err low
//   word - one-hot (ACTIVE_LOW=0) or one-cold (ACTIVE_LOW=1) decoded word
//   err  - sel addresses a line that does not exist (only while en=1)
module decoder_core #(
  parameter int SEL_W      = 2,
  parameter int NUM_OUT    = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_OUT-1:0] word,
  output logic               err
);

  logic [NUM_OUT-1:0] hot;

  always_comb begin
    hot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      hot[i] = en && (sel == SEL_W'(i));
    end
  end

  // Out-of-range selects leave hot all-zero, so only err needs handling.
  assign err  = en && (32'(sel) >= 32'(NUM_OUT));
  assign word = (ACTIVE_LOW != 0) ? ~hot : hot;

endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered select decoder with valid/ready handshake.
// One output beat is held; a new beat is accepted whenever the holding
// register is empty or being drained in the same cycle.
//
// Optional feature: define DECODER_PIPE_SCAN_EN to build a sweep FSM that,
// on a scan_start pulse, walks every output line once (sel 0..NUM_OUT-1).
// Without the macro scan_start is accepted but ignored.
//
// state | meaning
// IDLE  | external beats pass through; waits for scan_start
// SCAN  | external input blocked; internal beat sel=scan_cnt offered
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - input handshake
//   in_sel, in_en        - select value and decode enable
//   scan_start           - one-cycle sweep request
//   out_valid/out_ready  - output handshake
//   out_d, out_err       - decoded word, out-of-range flag
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int NUM_OUT    = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_en,
  input  logic               scan_start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_d,
  output logic               out_err
);

  localparam logic [NUM_OUT-1:0] INACTIVE = {NUM_OUT{ACTIVE_LOW != 0}};

  if (SEL_W < SEL_W_MIN || SEL_W > SEL_W_MAX) begin : g_bad_sel_w
    $error("decoder_pipe: SEL_W out of range");
  end
  if (NUM_OUT < 2 || NUM_OUT > (1 << SEL_W)) begin : g_bad_num_out
    $error("decoder_pipe: NUM_OUT out of range");
  end

  logic               beat_valid;
  logic               beat_ready;
  logic [SEL_W-1:0]   beat_sel;
  logic               beat_en;
  logic [NUM_OUT-1:0] dec_word;
  logic               dec_err;

  assign beat_ready = !out_valid || out_ready;

`ifdef DECODER_PIPE_SCAN_EN
  scan_state_t      state, state_nxt;
  logic [SEL_W-1:0] scan_cnt, scan_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      scan_cnt <= '0;
    end else begin
      state    <= state_nxt;
      scan_cnt <= scan_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    scan_cnt_nxt = scan_cnt;
    beat_valid   = in_valid;
    beat_sel     = in_sel;
    beat_en      = in_en;
    in_ready     = beat_ready;
    case (state)
      IDLE: begin
        if (scan_start) begin
          state_nxt    = SCAN;
          scan_cnt_nxt = '0;
        end
      end
      SCAN: begin
        in_ready   = 1'b0;
        beat_valid = 1'b1;
        beat_sel   = scan_cnt;
        beat_en    = 1'b1;
        if (beat_ready) begin
          if (scan_cnt == SEL_W'(NUM_OUT - 1)) begin
            state_nxt    = IDLE;
            scan_cnt_nxt = '0;
          end else begin
            scan_cnt_nxt = scan_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  logic unused_scan_start;
  assign unused_scan_start = scan_start;
  assign beat_valid = in_valid;
  assign beat_sel   = in_sel;
  assign beat_en    = in_en;
  assign in_ready   = beat_ready;
`endif

  decoder_core #(
    .SEL_W      (SEL_W),
    .NUM_OUT    (NUM_OUT),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_core (
    .sel  (beat_sel),
    .en   (beat_en),
    .word (dec_word),
    .err  (dec_err)
  );

  // On a drain with nothing new the word returns to the inactive level,
  // so out_d never shows a stale selection while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_d     <= INACTIVE;
      out_err   <= 1'b0;
    end else if (beat_valid && beat_ready) begin
      out_valid <= 1'b1;
      out_d     <= dec_word;
      out_err   <= dec_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_d     <= INACTIVE;
      out_err   <= 1'b0;
    end
  end

endmodule
